// File: rtl/time_set_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : time_set_pkg
//  Description : Shared types and constants for the time-set controller:
//                edit FSM states, blink-select encodings, BCD digit widths
//                and field limits.
//  Revision    : 1.0 - initial release
// ============================================================================
package time_set_pkg;

   // Edit session states
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_EDIT_HOUR = 2'd1,
      ST_EDIT_MIN  = 2'd2,
      ST_COMMIT    = 2'd3
   } state_t;

   // Display blink select
   localparam logic [1:0] FIELD_NONE = 2'b00;
   localparam logic [1:0] FIELD_HOUR = 2'b01;
   localparam logic [1:0] FIELD_MIN  = 2'b10;

   // BCD digit widths
   localparam int U_MIN_W  = 4;
   localparam int Z_MIN_W  = 3;
   localparam int U_HOUR_W = 4;
   localparam int Z_HOUR_W = 2;

   // Largest legal value of each two-digit field
   localparam int HOUR_MAX = 23;
   localparam int MIN_MAX  = 59;

   // True when the tens/units pair is a legal BCD hour
   function automatic logic hourValid(input logic [Z_HOUR_W-1:0] z,
                                      input logic [U_HOUR_W-1:0] u);
      return (u <= 4'd9) && ((int'(z) * 10 + int'(u)) <= HOUR_MAX);
   endfunction

   // True when the tens/units pair is a legal BCD minute
   function automatic logic minValid(input logic [Z_MIN_W-1:0] z,
                                     input logic [U_MIN_W-1:0] u);
      return (u <= 4'd9) && ((int'(z) * 10 + int'(u)) <= MIN_MAX);
   endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_pair_step.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_pair_step
//  Description : Combinational two-digit BCD +1/-1 with wrap at LIMIT and 0.
//                Simultaneous inc and dec leave the value unchanged.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_pair_step #(
   parameter int TENS_W = 3,
   parameter int LIMIT  = 59
) (
   input  logic [TENS_W-1:0] i_tens,
   input  logic [3:0]        i_units,
   input  logic              i_inc,
   input  logic              i_dec,
   output logic [TENS_W-1:0] o_tens,
   output logic [3:0]        o_units
);

   localparam logic [TENS_W-1:0] C_LIM_TENS  = TENS_W'(LIMIT / 10);
   localparam logic [3:0]        C_LIM_UNITS = 4'(LIMIT % 10);

   // Step the pair up or down, wrapping LIMIT <-> 00
   always_comb begin
      o_tens  = i_tens;
      o_units = i_units;
      if (i_inc && !i_dec) begin
         if (i_tens == C_LIM_TENS && i_units == C_LIM_UNITS) begin
            o_tens  = '0;
            o_units = 4'd0;
         end else if (i_units == 4'd9) begin
            o_tens  = i_tens + TENS_W'(1);
            o_units = 4'd0;
         end else begin
            o_units = i_units + 4'd1;
         end
      end else if (i_dec && !i_inc) begin
         if (i_tens == '0 && i_units == 4'd0) begin
            o_tens  = C_LIM_TENS;
            o_units = C_LIM_UNITS;
         end else if (i_units == 4'd0) begin
            o_tens  = i_tens - TENS_W'(1);
            o_units = 4'd9;
         end else begin
            o_units = i_units - 4'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/time_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : time_set_ctrl
//  Description : Button-driven edit session on a shadow copy of the current
//                time; issues a one-cycle parallel load of the edited BCD
//                digits and halts counting while editing.
//  Revision    : 1.0 - initial release
// ============================================================================
module time_set_ctrl
   import time_set_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 30000,
   parameter int TO_W           = 15
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                btn_mode,
   input  logic                btn_inc,
   input  logic                btn_dec,
   input  logic                btn_cancel,
   input  logic [U_MIN_W-1:0]  u_min_cur,
   input  logic [Z_MIN_W-1:0]  z_min_cur,
   input  logic [U_HOUR_W-1:0] u_hour_cur,
   input  logic [Z_HOUR_W-1:0] z_hour_cur,
   output logic [U_MIN_W-1:0]  u_min_set,
   output logic [Z_MIN_W-1:0]  z_min_set,
   output logic [U_HOUR_W-1:0] u_hour_set,
   output logic [Z_HOUR_W-1:0] z_hour_set,
   output logic                load,
   output logic                count_en,
   output logic [1:0]          edit_field
);

   localparam logic [TO_W-1:0] C_TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   state_t r_state, w_stateNext;

   logic r_modeQ, r_incQ, r_decQ, r_cancelQ;
   logic w_modeEdge, w_incEdge, w_decEdge, w_cancelEdge, w_anyEdge;
   logic w_inEdit, w_timeout, w_abort, w_stepOk;

   logic [TO_W-1:0] r_toCnt;

   logic [Z_HOUR_W-1:0] r_zHour, w_zHourNext;
   logic [U_HOUR_W-1:0] r_uHour, w_uHourNext;
   logic [Z_MIN_W-1:0]  r_zMin,  w_zMinNext;
   logic [U_MIN_W-1:0]  r_uMin,  w_uMinNext;

   assign w_modeEdge   = btn_mode   & ~r_modeQ;
   assign w_incEdge    = btn_inc    & ~r_incQ;
   assign w_decEdge    = btn_dec    & ~r_decQ;
   assign w_cancelEdge = btn_cancel & ~r_cancelQ;
   assign w_anyEdge    = w_modeEdge | w_incEdge | w_decEdge | w_cancelEdge;

   assign w_inEdit  = (r_state == ST_EDIT_HOUR) || (r_state == ST_EDIT_MIN);
   assign w_timeout = w_inEdit && (r_toCnt == C_TO_LAST);
   assign w_abort   = w_cancelEdge | w_timeout;
   // inc/dec only act when neither an abort nor a state advance wins
   assign w_stepOk  = w_inEdit & ~w_abort & ~w_modeEdge;

   // Previous button levels for rising-edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_modeQ   <= 1'b0;
         r_incQ    <= 1'b0;
         r_decQ    <= 1'b0;
         r_cancelQ <= 1'b0;
      end else begin
         r_modeQ   <= btn_mode;
         r_incQ    <= btn_inc;
         r_decQ    <= btn_dec;
         r_cancelQ <= btn_cancel;
      end
   end

   // Edit state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_stateNext;
   end

   // Next-state and Moore outputs
   always_comb begin
      w_stateNext = r_state;
      load        = 1'b0;
      count_en    = 1'b0;
      edit_field  = FIELD_NONE;
      case (r_state)
         ST_IDLE: begin
            count_en = 1'b1;
            if (w_modeEdge) w_stateNext = ST_EDIT_HOUR;
         end
         ST_EDIT_HOUR: begin
            edit_field = FIELD_HOUR;
            if (w_abort)         w_stateNext = ST_IDLE;
            else if (w_modeEdge) w_stateNext = ST_EDIT_MIN;
         end
         ST_EDIT_MIN: begin
            edit_field = FIELD_MIN;
            if (w_abort)         w_stateNext = ST_IDLE;
            else if (w_modeEdge) w_stateNext = ST_COMMIT;
         end
         ST_COMMIT: begin
            load        = 1'b1;
            w_stateNext = ST_IDLE;
         end
         default: w_stateNext = ST_IDLE;
      endcase
   end

   // Inactivity counter: cleared outside edit and on any press, saturates
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     r_toCnt <= '0;
      else if (!w_inEdit || w_anyEdge) r_toCnt <= '0;
      else if (r_toCnt != C_TO_LAST)  r_toCnt <= r_toCnt + TO_W'(1);
   end

   bcd_pair_step #(.TENS_W(Z_HOUR_W), .LIMIT(HOUR_MAX)) u_hourStep (
      .i_tens  (r_zHour),
      .i_units (r_uHour),
      .i_inc   (w_incEdge & w_stepOk & (r_state == ST_EDIT_HOUR)),
      .i_dec   (w_decEdge & w_stepOk & (r_state == ST_EDIT_HOUR)),
      .o_tens  (w_zHourNext),
      .o_units (w_uHourNext)
   );

   bcd_pair_step #(.TENS_W(Z_MIN_W), .LIMIT(MIN_MAX)) u_minStep (
      .i_tens  (r_zMin),
      .i_units (r_uMin),
      .i_inc   (w_incEdge & w_stepOk & (r_state == ST_EDIT_MIN)),
      .i_dec   (w_decEdge & w_stepOk & (r_state == ST_EDIT_MIN)),
      .o_tens  (w_zMinNext),
      .o_units (w_uMinNext)
   );

   // Shadow time: captured (sanitised) on session start, stepped while editing
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_zHour <= '0;
         r_uHour <= '0;
         r_zMin  <= '0;
         r_uMin  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_modeEdge) begin
                  if (hourValid(z_hour_cur, u_hour_cur)) begin
                     r_zHour <= z_hour_cur;
                     r_uHour <= u_hour_cur;
                  end else begin
                     r_zHour <= '0;
                     r_uHour <= '0;
                  end
                  if (minValid(z_min_cur, u_min_cur)) begin
                     r_zMin <= z_min_cur;
                     r_uMin <= u_min_cur;
                  end else begin
                     r_zMin <= '0;
                     r_uMin <= '0;
                  end
               end
            end
            ST_EDIT_HOUR: begin
               r_zHour <= w_zHourNext;
               r_uHour <= w_uHourNext;
            end
            ST_EDIT_MIN: begin
               r_zMin <= w_zMinNext;
               r_uMin <= w_uMinNext;
            end
            default: ;
         endcase
      end
   end

   assign z_hour_set = r_zHour;
   assign u_hour_set = r_uHour;
   assign z_min_set  = r_zMin;
   assign u_min_set  = r_uMin;

endmodule
`default_nettype wire

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Front-end writer for the time counter's parallel-load interface.
- Turns debounced user buttons into an edit session on a shadow copy of the current time, then issues a one-cycle load of the edited BCD digits into the counter.
- Halts counting (count_en low) while editing.
- Sits between the button debouncers and the time-counting block.

Parameters:
TIMEOUT_CYCLES, 30000, idle cycles in an edit state before auto-abort (30 s at 1 ms clk)
TO_W, 15, width of the timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
btn_mode  in  1  debounced level; rising edge advances edit state
btn_inc  in  1  debounced level; rising edge increments the field being edited
btn_dec  in  1  debounced level; rising edge decrements the field being edited
btn_cancel  in  1  debounced level; rising edge aborts edit without load
u_min_cur  in  4  current minute units from counter
z_min_cur  in  3  current minute tens
u_hour_cur  in  4  current hour units
z_hour_cur  in  2  current hour tens
u_min_set  out  4  edited minute units (to counter load input)
z_min_set  out  3  edited minute tens
u_hour_set  out  4  edited hour units
z_hour_set  out  2  edited hour tens
load  out  1  one-cycle parallel-load strobe
count_en  out  1  counter enable; low during edit/commit
edit_field  out  2  00 none, 01 hours, 10 minutes (display blink select)

Behaviour:
- Reset: state IDLE; all *_set = 0; load = 0; count_en = 1; edit_field = 00; timeout counter = 0; edge-detect registers = 0.
- Edge detect: each btn registered once; edge = btn & ~btn_q. It acts on the same clk edge where btn first samples 1. A held button yields exactly one edge.
- States: IDLE, EDIT_HOUR, EDIT_MIN, COMMIT.
- IDLE: count_en = 1, edit_field = 00. On mode edge:
  - capture *_cur into the shadow registers;
  - go to EDIT_HOUR.
  - Out-of-range captured field (hour > 23 or any digit > BCD max, e.g. z_min > 5, u_min > 9) is replaced by 00 for that field.
  - inc/dec/cancel edges in IDLE are ignored.
- EDIT_HOUR: count_en = 0, edit_field = 01.
  - inc: hour +1 in BCD; 09 -> 10, 19 -> 20, 23 -> 00.
  - dec: hour -1 in BCD; 10 -> 09, 00 -> 23.
  - mode edge -> EDIT_MIN.
- EDIT_MIN: count_en = 0, edit_field = 10.
  - inc: minute +1 in BCD; 59 -> 00. No carry or borrow into hours.
  - dec: minute -1 in BCD; 00 -> 59.
  - mode edge -> COMMIT.
- COMMIT: lasts exactly one cycle.
  - load = 1, count_en = 0, edit_field = 00.
  - *_set hold the shadow values.
  - Next state IDLE.
- Output hold: *_set always reflect the shadow registers and stay stable outside COMMIT; load is only ever high in COMMIT.
- Priority in edit states, highest first: cancel > mode > (inc XOR dec).
  - inc and dec edges in the same cycle: no change.
  - mode together with inc: state advances, inc dropped.
- Cancel edge in EDIT_HOUR or EDIT_MIN: go to IDLE, no load, shadow retained, count_en = 1 next cycle.
- Timeout:
  - Counter clears on entry to an edit state and on any btn edge.
  - Otherwise it increments each cycle in an edit state.
  - On reaching TIMEOUT_CYCLES - 1 it behaves as cancel, and the counter saturates (never wraps).
- Reset mid-edit or during COMMIT: immediate return to reset values; load deasserts asynchronously.
- Latency: mode edge in EDIT_MIN at cycle N -> load high in cycle N+1 -> count_en high in cycle N+2.

Decomposition:
- Package time_set_pkg holds:
  - the state enum and edit_field encodings;
  - digit widths (4/3/4/2);
  - field limits HOUR_MAX = 23 and MIN_MAX = 59.
- Sub-module bcd_pair_step: two-digit BCD +1/-1 with parameterised tens width and wrap limit.
  - Combinational; instanced once for hours (limit 23) and once for minutes (limit 59).

Test Plan:
- Reset then cur = 12:34: mode, inc x2, mode, dec, mode -> one load pulse with set = 14:33; count_en low from the first mode edge until the cycle after load.
- Hour wrap: cur 23:00, mode, inc -> shadow hour 00; then dec x2 -> 22. Minute wrap: 59 inc -> 00 and hours unchanged; 00 dec -> 59.
- Cancel in EDIT_MIN after edits -> no load ever asserted, count_en = 1 next cycle, edit_field = 00.
- TIMEOUT_CYCLES = 8, enter edit with no further presses -> IDLE after exactly 8 cycles, no load. A press at cycle 5 restarts the count.
- Simultaneous inc+dec edge -> value unchanged. mode+inc same cycle in EDIT_HOUR -> EDIT_MIN, hour unchanged. btn_inc held 100 cycles -> exactly +1.
- Invalid capture cur = 2'd3/4'd5 : 3'd7/4'd2 -> shadow 00:00. Async rst_n low during COMMIT -> load drops immediately and all outputs return to reset values.
